// File: rtl/fxp_mul_pipe_if.sv
// Handshake bundle for the pipelined fixed-point multiplier: operand/result
// valid/ready channels plus the saturation statistics controls.
interface fxp_mul_pipe_if #(
  parameter int N     = 16,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     result;
  logic             ovf;
  logic [CNT_W-1:0] ovf_cnt;
  logic             cnt_clr;

  modport master (
    output in_valid, a, b, out_ready, cnt_clr,
    input  in_ready, out_valid, result, ovf, ovf_cnt
  );

  modport slave (
    input  in_valid, a, b, out_ready, cnt_clr,
    output in_ready, out_valid, result, ovf, ovf_cnt
  );
endinterface

// File: rtl/fxp_mul_pipe.sv
// 3-stage signed Q(N-FRAC).FRAC multiplier: sign/magnitude split, split partial
// product multiply, then round + symmetric saturation, with an overflow event counter.
module fxp_mul_pipe #(
  parameter int N     = 16,
  parameter int FRAC  = 8,
  parameter int ROUND = 1,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  fxp_mul_pipe_if.slave   bus
);
  localparam int STAGES = 3;
  localparam int H      = N / 2;
  localparam int W      = 2 * N;

  localparam logic [N-1:0]     ONE  = N'(1);
  localparam logic [W-1:0]     MAXW = {{(N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic [N-1:0]     MAXP = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]     MAXN = {1'b1, {(N-2){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CONE = CNT_W'(1);

  logic [STAGES:1] vld_q;
  logic            adv;

  // Single global stall: every stage moves together, bubbles are kept.
  assign adv = !vld_q[STAGES] | bus.out_ready;

  // S1: sign and magnitudes; |-2^(N-1)| still fits as unsigned N bits.
  logic [N-1:0] ma_d, mb_d, ma_q, mb_q;
  logic         sgn1_q, zro1_q;

  assign ma_d = bus.a[N-1] ? (~bus.a + ONE) : bus.a;
  assign mb_d = bus.b[N-1] ? (~bus.b + ONE) : bus.b;

  // S2: four half-width partial products summed at full 2N width.
  logic [N-1:0] pp_hh, pp_hl, pp_lh, pp_ll;
  logic [W-1:0] p_d, p_q;
  logic         sgn2_q, zro2_q;

  assign pp_hh = {{H{1'b0}}, ma_q[N-1:H]} * {{H{1'b0}}, mb_q[N-1:H]};
  assign pp_hl = {{H{1'b0}}, ma_q[N-1:H]} * {{H{1'b0}}, mb_q[H-1:0]};
  assign pp_lh = {{H{1'b0}}, ma_q[H-1:0]} * {{H{1'b0}}, mb_q[N-1:H]};
  assign pp_ll = {{H{1'b0}}, ma_q[H-1:0]} * {{H{1'b0}}, mb_q[H-1:0]};

  assign p_d = {pp_hh, {N{1'b0}}}
             + ({{N{1'b0}}, pp_hl} << H)
             + ({{N{1'b0}}, pp_lh} << H)
             + {{N{1'b0}}, pp_ll};

  // S3: scale, round half away from zero on the magnitude, then saturate.
  logic [W-1:0] m_d;
  logic [N-1:0] res_d, res_q;
  logic         ovf_d, ovf_q;
  logic         unused_p;

  assign unused_p = ^p_q;

  generate
    if (ROUND != 0 && FRAC > 0) begin : g_rnd
      assign m_d = (p_q >> FRAC) + {{(W-1){1'b0}}, p_q[FRAC-1]};
    end else begin : g_trunc
      assign m_d = p_q >> FRAC;
    end
  endgenerate

  always_comb begin
    ovf_d = 1'b0;
    res_d = '0;
    if (!zro2_q) begin
      if (m_d > MAXW) begin
        ovf_d = 1'b1;
        res_d = sgn2_q ? MAXN : MAXP;
      end else begin
        res_d = sgn2_q ? (~m_d[N-1:0] + ONE) : m_d[N-1:0];
      end
    end
  end

  logic [CNT_W-1:0] cnt_q;
  logic             ovf_evt;

  assign ovf_evt = vld_q[STAGES] & bus.out_ready & ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      ma_q   <= '0;
      mb_q   <= '0;
      sgn1_q <= 1'b0;
      zro1_q <= 1'b0;
      p_q    <= '0;
      sgn2_q <= 1'b0;
      zro2_q <= 1'b0;
      res_q  <= '0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (adv) begin
        vld_q  <= {vld_q[STAGES-1:1], bus.in_valid};
        ma_q   <= ma_d;
        mb_q   <= mb_d;
        sgn1_q <= bus.a[N-1] ^ bus.b[N-1];
        zro1_q <= (bus.a == '0) | (bus.b == '0);
        p_q    <= p_d;
        sgn2_q <= sgn1_q;
        zro2_q <= zro1_q;
        res_q  <= res_d;
        ovf_q  <= ovf_d;
      end
      // Clear wins over a coincident event; counter sticks at all-ones.
      if (bus.cnt_clr)
        cnt_q <= '0;
      else if (ovf_evt && !(&cnt_q))
        cnt_q <= cnt_q + CONE;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_q[STAGES];
  assign bus.result    = res_q;
  assign bus.ovf       = ovf_q;
  assign bus.ovf_cnt   = cnt_q;
endmodule

// File: tb/tb_fxp_mul_pipe.sv
// Bench for fxp_mul_pipe (N=16, FRAC=8): a rounding and a truncating instance share
// stimulus; expected results go through a scoreboard and are popped on output transfer.
module tb_fxp_mul_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic cnt_clr = 1'b0;
  logic [15:0] a = '0, b = '0;

  always #5 clk = ~clk;

  fxp_mul_pipe_if #(.N(16), .CNT_W(16)) bus1 ();
  fxp_mul_pipe_if #(.N(16), .CNT_W(16)) bus0 ();

  assign bus1.in_valid = in_valid;  assign bus0.in_valid = in_valid;
  assign bus1.a = a;                assign bus0.a = a;
  assign bus1.b = b;                assign bus0.b = b;
  assign bus1.out_ready = out_ready; assign bus0.out_ready = out_ready;
  assign bus1.cnt_clr = cnt_clr;    assign bus0.cnt_clr = cnt_clr;

  fxp_mul_pipe #(.N(16), .FRAC(8), .ROUND(1), .CNT_W(16)) dut_rnd (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  fxp_mul_pipe #(.N(16), .FRAC(8), .ROUND(0), .CNT_W(16)) dut_trc (
    .clk(clk), .rst_n(rst_n), .bus(bus0));

  typedef struct {
    logic [15:0] r1; logic o1;
    logic [15:0] r0; logic o0;
  } exp_t;

  typedef struct {
    logic [15:0] a, b, r1, r0;
    logic        o;
  } vec_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  logic [15:0] cnt_m = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: full signed product in 64-bit arithmetic, scaled by 2^-8.
  function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y, input bit rnd);
    longint p, mag, m;
    bit neg;
    logic [15:0] r;
    p   = longint'($signed(x)) * longint'($signed(y));
    neg = (p < 0);
    mag = neg ? -p : p;
    m   = mag >> 8;
    if (rnd) m = m + ((mag >> 7) & 1);
    if (mag == 0) return 17'h0;
    if (m > 32767) return {1'b1, (neg ? 16'h8001 : 16'h7FFF)};
    r = neg ? 16'(-m) : 16'(m);
    return {1'b0, r};
  endfunction

  function automatic exp_t mk(input logic [15:0] x, input logic [15:0] y);
    exp_t e;
    logic [16:0] t1, t0;
    t1 = model(x, y, 1'b1);
    t0 = model(x, y, 1'b0);
    e.r1 = t1[15:0]; e.o1 = t1[16];
    e.r0 = t0[15:0]; e.o0 = t0[16];
    return e;
  endfunction

  // Called at posedge+1; holds the pair until accepted, then pushes its expectation.
  task automatic send(input logic [15:0] x, input logic [15:0] y, input exp_t e);
    bit ok = 1'b0;
    a = x; b = y; in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus1.in_ready) begin
        sb.push_back(e);
        ok = 1'b1;
      end
    end
    if (!ok) begin
      miscompares++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 for a=%h b=%h", x, y);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Output monitor: handshake relation, counter, stall stability, scoreboard pop.
  logic        held_v = 1'b0;
  logic [15:0] held_r;
  logic        held_o;

  always @(negedge clk) begin
    exp_t e;
    bool_xfer: begin end
    if (!rst_n) begin
      sb.delete();
      cnt_m  = '0;
      held_v = 1'b0;
    end else begin
      chk("in_ready", bus1.in_ready, !bus1.out_valid | out_ready);
      chk("ovf_cnt", bus1.ovf_cnt, cnt_m);
      chk("valid_match", bus0.out_valid, bus1.out_valid);
      if (held_v && bus1.out_valid) begin
        chk("stall_result", bus1.result, held_r);
        chk("stall_ovf", bus1.ovf, held_o);
      end
      if (bus1.out_valid && out_ready) begin
        if (sb.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL sb_underflow: got an output, expected none at %0t", $time);
          e = '{r1: 16'h0, o1: 1'b0, r0: 16'h0, o0: 1'b0};
        end else begin
          e = sb.pop_front();
          chk("result_rnd", bus1.result, e.r1);
          chk("ovf_rnd", bus1.ovf, e.o1);
          chk("result_trc", bus0.result, e.r0);
          chk("ovf_trc", bus0.ovf, e.o0);
        end
        if (!cnt_clr && e.o1 && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
      end
      if (cnt_clr) cnt_m = '0;
      held_v = bus1.out_valid && !out_ready;
      held_r = bus1.result;
      held_o = bus1.ovf;
    end
  end

  vec_t tbl[14];

  initial begin
    logic [15:0] av, bv;
    bit seen;
    tbl[0]  = '{a:16'h0180, b:16'h0200, r1:16'h0300, r0:16'h0300, o:1'b0};
    tbl[1]  = '{a:16'hFE80, b:16'h0200, r1:16'hFD00, r0:16'hFD00, o:1'b0};
    tbl[2]  = '{a:16'hFE80, b:16'hFE00, r1:16'h0300, r0:16'h0300, o:1'b0};
    tbl[3]  = '{a:16'h7F00, b:16'h0200, r1:16'h7FFF, r0:16'h7FFF, o:1'b1};
    tbl[4]  = '{a:16'h8000, b:16'h0200, r1:16'h8001, r0:16'h8001, o:1'b1};
    tbl[5]  = '{a:16'h8000, b:16'h0000, r1:16'h0000, r0:16'h0000, o:1'b0};
    tbl[6]  = '{a:16'h0001, b:16'h0080, r1:16'h0001, r0:16'h0000, o:1'b0};
    tbl[7]  = '{a:16'hFFFF, b:16'h0080, r1:16'hFFFF, r0:16'h0000, o:1'b0};
    tbl[8]  = '{a:16'h0003, b:16'h0080, r1:16'h0002, r0:16'h0001, o:1'b0};
    tbl[9]  = '{a:16'hFFFD, b:16'h0080, r1:16'hFFFE, r0:16'hFFFF, o:1'b0};
    tbl[10] = '{a:16'h7FFF, b:16'h7FFF, r1:16'h7FFF, r0:16'h7FFF, o:1'b1};
    tbl[11] = '{a:16'h8000, b:16'hFF00, r1:16'h7FFF, r0:16'h7FFF, o:1'b1};
    tbl[12] = '{a:16'h7FFF, b:16'hFF00, r1:16'h8001, r0:16'h8001, o:1'b0};
    tbl[13] = '{a:16'h0100, b:16'h0100, r1:16'h0100, r0:16'h0100, o:1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus1.out_valid, 1'b0);
    chk("rst_result", bus1.result, 16'h0);
    chk("rst_ovf", bus1.ovf, 1'b0);
    chk("rst_ovf_cnt", bus1.ovf_cnt, 16'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", bus1.in_ready, 1'b1);

    // Directed table, back to back.
    for (int i = 0; i < 14; i++)
      send(tbl[i].a, tbl[i].b,
           '{r1: tbl[i].r1, o1: tbl[i].o, r0: tbl[i].r0, o0: tbl[i].o});
    repeat (5) @(posedge clk);
    #1;

    // Random stream, full throughput.
    for (int i = 0; i < 12; i++) begin
      av = 16'($urandom); bv = 16'($urandom_range(0, 16'h03FF));
      if ($urandom_range(0, 1) == 1) bv = -bv;
      send(av, bv, mk(av, bv));
    end
    repeat (5) @(posedge clk);
    #1;

    // Back-pressure: out_ready low for three cycles mid-stream.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          av = 16'($urandom); bv = 16'($urandom);
          send(av, bv, mk(av, bv));
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    chk("bp_drain", sb.size(), 0);

    // Reset with three operations in flight.
    send(16'h7F00, 16'h0200, mk(16'h7F00, 16'h0200));
    send(16'h0180, 16'h0200, mk(16'h0180, 16'h0200));
    send(16'h8000, 16'h0200, mk(16'h8000, 16'h0200));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus1.out_valid, 1'b0);
    chk("midrst_ovf_cnt", bus1.ovf_cnt, 16'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_idle", bus1.out_valid, 1'b0);

    // Clear coincident with an overflow output transfer.
    send(16'h7F00, 16'h0200, mk(16'h7F00, 16'h0200));
    repeat (5) @(posedge clk);
    #1;
    chk("cnt_one", bus1.ovf_cnt, 16'h1);
    send(16'h8000, 16'h0200, mk(16'h8000, 16'h0200));
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (bus1.out_valid) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("clr_out_seen", seen, 1'b1);
    chk("clr_out_ovf", bus1.ovf, 1'b1);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("cnt_clr_coinc", bus1.ovf_cnt, 16'h0);

    repeat (6) @(posedge clk);
    #1;
    chk("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
